// File: rtl/scan_select_sequencer.sv
// Scan-select sequencer: steps a 3-bit decoder index through the enabled channels
// with a programmable dwell. Define SCAN_BLANK_EN to insert a blanking gap between channels.
module scan_select_sequencer #(
    parameter int DWELL_W      = 8,
    parameter int BLANK_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic [7:0]         ch_mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         sel,
    output logic               sel_valid,
    output logic               busy,
    output logic               frame_done
);

    typedef enum logic [1:0] {IDLE, ACTIVE, BLANK} state_t;

    state_t             state, nxt_state;
    logic [7:0]         mask_q, nxt_mask;
    logic [DWELL_W-1:0] dwell_q, nxt_dwell;
    logic [DWELL_W-1:0] cnt, nxt_cnt;
    logic [2:0]         nxt_sel;
    logic [3:0]         up, nxt_up;
    logic [2:0]         wrap_sel;

    // {found, index} of the lowest set bit of m strictly above s
    function automatic logic [3:0] next_above(input logic [7:0] m, input logic [2:0] s);
        logic [3:0] r;
        r = 4'b0000;
        for (int i = 7; i >= 0; i--) begin
            if (m[i] && (i > int'(s)))
                r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    function automatic logic [2:0] lowest_bit(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i])
                r = 3'(i);
        end
        return r;
    endfunction

`ifdef SCAN_BLANK_EN
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    logic [BW-1:0] bcnt, nxt_bcnt;
`endif

    assign up       = next_above(mask_q, sel);
    assign wrap_sel = lowest_bit(ch_mask);
    assign nxt_up   = next_above(nxt_mask, nxt_sel);

    always_comb begin
        nxt_state = state;
        nxt_mask  = mask_q;
        nxt_dwell = dwell_q;
        nxt_cnt   = cnt;
        nxt_sel   = sel;
`ifdef SCAN_BLANK_EN
        nxt_bcnt  = bcnt;
`endif
        case (state)
            IDLE: begin
                if (!stop && start && (ch_mask != 8'h00)) begin
                    nxt_state = ACTIVE;
                    nxt_mask  = ch_mask;
                    nxt_dwell = dwell;
                    nxt_sel   = wrap_sel;
                    nxt_cnt   = '0;
                end
            end
            ACTIVE: begin
                if (stop) begin
                    nxt_state = IDLE;
                end else if (cnt != dwell_q) begin
                    nxt_cnt = cnt + 1'b1;
                end else if (up[3]) begin
                    nxt_sel = up[2:0];
                    nxt_cnt = '0;
`ifdef SCAN_BLANK_EN
                    nxt_state = BLANK;
                    nxt_bcnt  = '0;
`endif
                end else if (cont && (ch_mask != 8'h00)) begin
                    // Continuous wrap picks up whatever mask/dwell is presented now
                    nxt_mask  = ch_mask;
                    nxt_dwell = dwell;
                    nxt_sel   = wrap_sel;
                    nxt_cnt   = '0;
`ifdef SCAN_BLANK_EN
                    nxt_state = BLANK;
                    nxt_bcnt  = '0;
`endif
                end else begin
                    nxt_state = IDLE;
                end
            end
`ifdef SCAN_BLANK_EN
            BLANK: begin
                if (stop)
                    nxt_state = IDLE;
                else if (bcnt == BW'(BLANK_CYCLES - 1))
                    nxt_state = ACTIVE;
                else
                    nxt_bcnt = bcnt + 1'b1;
            end
`endif
            default: nxt_state = IDLE;
        endcase
    end

    // frame_done is registered, so it is computed from the next-cycle state:
    // high when the coming cycle is the terminal dwell of the last channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            mask_q     <= '0;
            dwell_q    <= '0;
            cnt        <= '0;
            sel        <= '0;
            sel_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef SCAN_BLANK_EN
            bcnt       <= '0;
`endif
        end else begin
            state      <= nxt_state;
            mask_q     <= nxt_mask;
            dwell_q    <= nxt_dwell;
            cnt        <= nxt_cnt;
            sel        <= nxt_sel;
            sel_valid  <= (nxt_state == ACTIVE);
            busy       <= (nxt_state != IDLE);
            frame_done <= (nxt_state == ACTIVE) && (nxt_cnt == nxt_dwell) && !nxt_up[3];
`ifdef SCAN_BLANK_EN
            bcnt       <= nxt_bcnt;
`endif
        end
    end

endmodule

// File: tb/tb_scan_select_sequencer.sv
// Bench for scan_select_sequencer (default build): directed scenarios plus random
// stimulus against a channel-schedule queue model.
module tb_scan_select_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, stop = 1'b0, cont = 1'b0;
    logic [7:0] ch_mask = 8'h00;
    logic [7:0] dwell = 8'h00;
    logic [2:0] sel;
    logic       sel_valid, busy, frame_done;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of channel indices, one entry per active cycle of the frame
    int         q[$];
    bit         m_busy = 1'b0;
    logic [2:0] m_sel  = 3'd0;

    scan_select_sequencer #(.DWELL_W(8), .BLANK_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .cont(cont),
        .ch_mask(ch_mask), .dwell(dwell), .sel(sel), .sel_valid(sel_valid),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic fill(input logic [7:0] m, input logic [7:0] d);
        for (int i = 0; i < 8; i++)
            if (m[i])
                for (int k = 0; k <= int'(d); k++) q.push_back(i);
    endtask

    task automatic model_reset();
        q.delete();
        m_busy = 1'b0;
        m_sel  = 3'd0;
    endtask

    task automatic model_edge(input logic st, input logic sp, input logic ct,
                              input logic [7:0] m, input logic [7:0] d);
        if (sp) begin
            q.delete();
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (st && m != 8'h00) begin
                fill(m, d);
                m_busy = 1'b1;
            end
        end else begin
            void'(q.pop_front());
            if (q.size() == 0) begin
                if (ct && m != 8'h00) fill(m, d);
                else m_busy = 1'b0;
            end
        end
        if (m_busy) m_sel = 3'(q[0]);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".sel"},   {5'd0, sel}, {5'd0, m_sel});
        check({tag, ".valid"}, {7'd0, sel_valid}, {7'd0, m_busy});
        check({tag, ".busy"},  {7'd0, busy}, {7'd0, m_busy});
        check({tag, ".fdone"}, {7'd0, frame_done}, {7'd0, (m_busy && q.size() == 1)});
    endtask

    // Called at a negedge: drive, clock, update model, compare at the next negedge
    task automatic step(input string tag, input logic st, input logic sp, input logic ct,
                        input logic [7:0] m, input logic [7:0] d);
        start = st; stop = sp; cont = ct; ch_mask = m; dwell = d;
        @(posedge clk);
        model_edge(st, sp, ct, m, d);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0; stop = 1'b0; cont = 1'b0; ch_mask = 8'h00; dwell = 8'h00;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int nvalid;
        bit hit;

        // Reset state and start with an empty mask
        do_reset();
        check_outputs("reset");
        step("empty_start", 1'b1, 1'b0, 1'b0, 8'h00, 8'd2);
        step("empty_idle", 1'b0, 1'b0, 1'b0, 8'h00, 8'd2);

        // Single frame A5, dwell 2: 12 valid cycles then idle
        nvalid = 0;
        step("a5", 1'b1, 1'b0, 1'b0, 8'hA5, 8'd2);
        nvalid += int'(sel_valid);
        for (int i = 0; i < 13; i++) begin
            step("a5", 1'b0, 1'b0, 1'b0, 8'hA5, 8'd2);
            nvalid += int'(sel_valid);
        end
        check("a5.valid_cycles", 8'(nvalid), 8'd12);

        // Continuous 81, dwell 0; mask changed to 10 mid-frame takes effect at the wrap
        step("c81", 1'b1, 1'b0, 1'b1, 8'h81, 8'd0);
        for (int i = 0; i < 5; i++) step("c81", 1'b0, 1'b0, 1'b1, 8'h81, 8'd0);
        step("c81_chg", 1'b0, 1'b0, 1'b1, 8'h10, 8'd0);
        for (int i = 0; i < 4; i++) step("c10", 1'b0, 1'b0, 1'b1, 8'h10, 8'd0);
        check("c10.sel_direct", {5'd0, sel}, 8'd4);
        step("c10_stop", 1'b0, 1'b1, 1'b1, 8'h10, 8'd0);

        // Stop on the 2nd dwell cycle of channel 2, then start+stop together
        step("ff", 1'b1, 1'b0, 1'b0, 8'hFF, 8'd3);
        for (int i = 0; i < 9; i++) step("ff", 1'b0, 1'b0, 1'b0, 8'hFF, 8'd3);
        check("ff.sel_before_stop", {5'd0, sel}, 8'd2);
        step("ff_stop", 1'b0, 1'b1, 1'b0, 8'hFF, 8'd3);
        step("start_stop", 1'b1, 1'b1, 1'b0, 8'hFF, 8'd3);
        step("start_stop_idle", 1'b0, 1'b0, 1'b0, 8'hFF, 8'd3);

        // Asynchronous reset while scanning channel 5
        hit = 1'b0;
        step("ar", 1'b1, 1'b0, 1'b1, 8'hFF, 8'd1);
        for (int i = 0; i < 40 && !hit; i++) begin
            if (m_busy && m_sel == 3'd5) hit = 1'b1;
            else step("ar", 1'b0, 1'b0, 1'b1, 8'hFF, 8'd1);
        end
        check("ar.reached_sel5", {7'd0, hit}, 8'd1);
        #2 rst = 1'b1;
        #1;
        check("ar.sel",   {5'd0, sel}, 8'd0);
        check("ar.valid", {7'd0, sel_valid}, 8'd0);
        check("ar.busy",  {7'd0, busy}, 8'd0);
        check("ar.fdone", {7'd0, frame_done}, 8'd0);
        @(negedge clk);
        do_reset();
        check_outputs("ar_release");

        // Random stimulus
        for (int i = 0; i < 600; i++) begin
            logic       st, sp, ct;
            logic [7:0] m, d;
            st = ($urandom_range(0, 3) == 0);
            sp = ($urandom_range(0, 24) == 0);
            ct = $urandom_range(0, 1) == 1;
            m  = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            d  = 8'($urandom_range(0, 3));
            step("rand", st, sp, ct, m, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
